// File: rtl/rf_wrport_arb.sv
// rtl/rf_wrport_arb.sv - register-file write-port arbiter (retire > ld FIFO, post-reset clear); optional counters under RF_WRPORT_ARB_STATS_EN
module rf_wrport_arb #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rb_wren,
  input  logic [ADDR_W-1:0] rb_wraddr,
  input  logic [DATA_W-1:0] rb_wrdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_wraddr,
  input  logic [DATA_W-1:0] ld_wrdata,
  output logic              init_busy,
  output logic              rf_wren,
  output logic [ADDR_W-1:0] rf_wraddr,
  output logic [DATA_W-1:0] rf_wrdata
`ifdef RF_WRPORT_ARB_STATS_EN
  ,
  output logic [31:0]       stat_ld_blocked,
  output logic [31:0]       stat_squash,
  output logic [31:0]       stat_rb_preempt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_W-1:0]     r_clr_idx;

  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  r_rf_wren;
  logic [ADDR_W-1:0]     r_rf_wraddr;
  logic [DATA_W-1:0]     r_rf_wrdata;

  logic                  w_run;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_head_present;
  logic                  w_head_vld;
  logic [ADDR_W-1:0]     w_head_addr;
  logic [DATA_W-1:0]     w_head_data;
  logic                  w_rb_win;
  logic                  w_pop;
  logic                  w_ld_write;
  logic                  w_push_squash;
  logic [FIFO_DEPTH-1:0] w_squash;
  logic [FIFO_DEPTH-1:0] w_pop_mask;

  // Ready comes from the registered count only; a same-cycle pop never opens a slot early.
  assign w_run          = (r_state == ST_RUN);
  assign w_ready        = w_run && (r_count < CNT_FULL);
  assign w_push         = ld_valid && w_ready;

  // Head view: an entry exists when count is nonzero; it may have been invalidated by a squash.
  assign w_head_present = (r_count != '0);
  assign w_head_vld     = w_head_present && r_fifo_vld[r_rd_ptr];
  assign w_head_addr    = r_fifo_addr[r_rd_ptr];
  assign w_head_data    = r_fifo_data[r_rd_ptr];

  // Retire to x0 is not a write, so it neither takes the port nor squashes anything.
  assign w_rb_win       = w_run && rb_wren && (rb_wraddr != '0);

  // An invalid head drains even while retire owns the port; a valid head only drains when it gets the port.
  assign w_pop          = w_run && w_head_present && (!w_head_vld || !w_rb_win);
  assign w_ld_write     = !w_rb_win && w_head_vld && (w_head_addr != '0);

  // An entry arriving in the same cycle as a younger retire write to its register is born dead.
  assign w_push_squash  = w_rb_win && (ld_wraddr == rb_wraddr);

  assign ld_ready       = w_ready;
  assign init_busy      = (r_state == ST_CLEAR);
  assign rf_wren        = r_rf_wren;
  assign rf_wraddr      = r_rf_wraddr;
  assign rf_wrdata      = r_rf_wrdata;

  // Per-entry squash: every still-valid entry aimed at the retiring register loses its valid.
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_squash[i] = w_rb_win && r_fifo_vld[i] && (r_fifo_addr[i] == rb_wraddr);
    end
  end

  // One-hot mask of the slot being popped this cycle.
  always_comb begin
    w_pop_mask = '0;
    w_pop_mask[r_rd_ptr] = w_pop;
  end

  // Clear sequencer: walk x1..x(NUM_REGS-1) once, then hand the port to normal arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= ADDR_W'(1);
    end else if (r_state == ST_CLEAR) begin
      r_clr_idx <= r_clr_idx + ADDR_W'(1);
      if (r_clr_idx == CLR_LAST) begin
        r_state <= ST_RUN;
      end
    end
  end

  // FIFO control: entry valids, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_vld <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_fifo_vld <= r_fifo_vld & ~w_squash & ~w_pop_mask;
      if (w_push) begin
        r_fifo_vld[r_wr_ptr] <= !w_push_squash;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // FIFO payload storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= ld_wraddr;
      r_fifo_data[r_wr_ptr] <= ld_wrdata;
    end
  end

  // Registered write command: clear, then retire, then FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rf_wren   <= 1'b0;
      r_rf_wraddr <= '0;
      r_rf_wrdata <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_rf_wren   <= 1'b1;
      r_rf_wraddr <= r_clr_idx;
      r_rf_wrdata <= '0;
    end else if (w_rb_win) begin
      r_rf_wren   <= 1'b1;
      r_rf_wraddr <= rb_wraddr;
      r_rf_wrdata <= rb_wrdata;
    end else if (w_ld_write) begin
      r_rf_wren   <= 1'b1;
      r_rf_wraddr <= w_head_addr;
      r_rf_wrdata <= w_head_data;
    end else begin
      r_rf_wren   <= 1'b0;
    end
  end

`ifdef RF_WRPORT_ARB_STATS_EN
  logic [31:0] r_stat_ld_blocked;
  logic [31:0] r_stat_squash;
  logic [31:0] r_stat_rb_preempt;
  logic [31:0] w_squash_cnt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Entries killed this cycle, including one that is squashed on its way in.
  always_comb begin
    w_squash_cnt = 32'(w_push && w_push_squash);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_squash_cnt = w_squash_cnt + 32'(w_squash[i]);
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ld_blocked <= '0;
      r_stat_squash     <= '0;
      r_stat_rb_preempt <= '0;
    end else begin
      r_stat_ld_blocked <= sat_add(r_stat_ld_blocked, 32'(w_run && ld_valid && !w_ready));
      r_stat_squash     <= sat_add(r_stat_squash, w_squash_cnt);
      r_stat_rb_preempt <= sat_add(r_stat_rb_preempt, 32'(w_rb_win && w_head_vld));
    end
  end

  assign stat_ld_blocked = r_stat_ld_blocked;
  assign stat_squash     = r_stat_squash;
  assign stat_rb_preempt = r_stat_rb_preempt;
`endif

`ifndef SYNTHESIS
  // Retire traffic during the clear sequence is an upstream protocol violation.
  a_no_rb_in_clear: assert property (@(posedge clk) disable iff (!reset_n)
    !((r_state == ST_CLEAR) && rb_wren));
`endif

endmodule

// File: tb/tb_rf_wrport_arb.sv
// tb/tb_rf_wrport_arb.sv - randomized and directed bench for rf_wrport_arb against a queue-based model
module tb_rf_wrport_arb;
  localparam int NR = 32;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rb_wren = 1'b0;
  logic [4:0]  rb_wraddr = '0;
  logic [31:0] rb_wrdata = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_wraddr = '0;
  logic [31:0] ld_wrdata = '0;
  logic        init_busy;
  logic        rf_wren;
  logic [4:0]  rf_wraddr;
  logic [31:0] rf_wrdata;

  int checks = 0;
  int failures = 0;

  rf_wrport_arb #(.NUM_REGS(NR), .ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n),
    .rb_wren(rb_wren), .rb_wraddr(rb_wraddr), .rb_wrdata(rb_wrdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wraddr(ld_wraddr), .ld_wrdata(ld_wrdata),
    .init_busy(init_busy),
    .rf_wren(rf_wren), .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        q[$];
  bit          m_clr;
  int          m_idx;
  logic        m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    q.delete();
    m_clr  = 1'b1;
    m_idx  = 1;
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic bit m_ready();
    return !m_clr && (q.size() < FD);
  endfunction

  // One clock: model consumes the inputs present at the edge, then sample at the next negedge.
  task automatic step();
    bit   win;
    bit   push;
    ent_t e;
    push   = ld_valid && m_ready();
    m_wren = 1'b0;
    if (m_clr) begin
      m_wren = 1'b1;
      m_addr = m_idx[4:0];
      m_data = '0;
      if (m_idx == NR - 1) m_clr = 1'b0;
      m_idx++;
    end else begin
      win = rb_wren && (rb_wraddr != 0);
      if (win) begin
        m_wren = 1'b1;
        m_addr = rb_wraddr;
        m_data = rb_wrdata;
        if (q.size() > 0 && !q[0].v) void'(q.pop_front());
        foreach (q[i]) if (q[i].a == rb_wraddr) q[i].v = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.v && e.a != 0) begin
          m_wren = 1'b1;
          m_addr = e.a;
          m_data = e.d;
        end
      end
      if (push) begin
        e.a = ld_wraddr;
        e.d = ld_wrdata;
        e.v = !(win && ld_wraddr == rb_wraddr);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rb_wren  = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rf_wren, rf_wraddr, rf_wrdata} !== 38'd0) begin
      failures++;
      $display("FAIL reset_rf: got wren=%b addr=%0d data=%h, expected all zero", rf_wren, rf_wraddr, rf_wrdata);
    end
    checks++;
    if (init_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b expected 1", init_busy);
    end
    checks++;
    if (ld_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 0", ld_ready);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= NR; k++) begin
      step();
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL clear_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 k, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      checks++;
      if (k < NR && (rf_wren !== 1'b1 || rf_wraddr !== 5'(k) || rf_wrdata !== 32'd0)) begin
        failures++;
        $display("FAIL clear_write%0d: got wren=%b addr=%0d data=%h, expected 1/%0d/0", k, rf_wren, rf_wraddr, rf_wrdata, k);
      end else if (k == NR && (rf_wren !== 1'b0 || init_busy !== 1'b0 || ld_ready !== 1'b1)) begin
        failures++;
        $display("FAIL clear_done: got wren=%b busy=%b rdy=%b, expected 0/0/1", rf_wren, init_busy, ld_ready);
      end
    end
  endtask

  task automatic test_single_ld();
    idle_inputs();
    repeat (2) step();
    ld_valid  = 1'b1;
    ld_wraddr = 5'd5;
    ld_wrdata = 32'hDEADBEEF;
    for (int c = 0; c < 4; c++) begin
      step();
      ld_valid = 1'b0;
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL single_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 c, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      if (c == 0) begin
        checks++;
        if (rf_wren !== 1'b0) begin
          failures++;
          $display("FAIL single_early: got wren=%b at push+1, expected 0", rf_wren);
        end
      end
      if (c == 1) begin
        checks++;
        if ({rf_wren, rf_wraddr, rf_wrdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
          failures++;
          $display("FAIL single_write: got wren=%b addr=%0d data=%h, expected 1/5/deadbeef", rf_wren, rf_wraddr, rf_wrdata);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [4:0] exp_seq [8];
    int np;
    bit will_push;
    exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3, 5'd4};
    np = 0;
    idle_inputs();
    repeat (2) step();
    for (int c = 0; c < 12; c++) begin
      rb_wren   = (c < 4);
      rb_wraddr = 5'(10 + c);
      rb_wrdata = $urandom;
      ld_valid  = (np < 4);
      ld_wraddr = 5'(np + 1);
      ld_wrdata = $urandom;
      will_push = ld_valid && m_ready();
      step();
      if (will_push) np++;
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL full_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 c, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      if (c == 3) begin
        checks++;
        if (ld_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_ready: got %b after 4th push, expected 0", ld_ready);
        end
      end
      checks++;
      if (c < 8 && (rf_wren !== 1'b1 || rf_wraddr !== exp_seq[c])) begin
        failures++;
        $display("FAIL full_order%0d: got wren=%b addr=%0d, expected 1/%0d", c, rf_wren, rf_wraddr, exp_seq[c]);
      end else if (c >= 8 && rf_wren !== 1'b0) begin
        failures++;
        $display("FAIL full_tail%0d: got wren=%b, expected 0", c, rf_wren);
      end
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    int n7;
    bit saw_stale, saw_new, saw_8;
    n7 = 0; saw_stale = 0; saw_new = 0; saw_8 = 0;
    idle_inputs();
    repeat (2) step();
    for (int c = 0; c < 8; c++) begin
      rb_wren = 1'b0;
      ld_valid = 1'b0;
      case (c)
        0: begin rb_wren = 1; rb_wraddr = 5'd20; rb_wrdata = $urandom; ld_valid = 1; ld_wraddr = 5'd7; ld_wrdata = 32'h1; end
        1: begin rb_wren = 1; rb_wraddr = 5'd21; rb_wrdata = $urandom; ld_valid = 1; ld_wraddr = 5'd8; ld_wrdata = 32'h2; end
        2: begin rb_wren = 1; rb_wraddr = 5'd7;  rb_wrdata = 32'h99; end
        default: ;
      endcase
      step();
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL squash_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 c, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      if (rf_wren === 1'b1 && rf_wraddr === 5'd7) n7++;
      if (rf_wren === 1'b1 && rf_wraddr === 5'd7 && rf_wrdata === 32'h1) saw_stale = 1;
      if (rf_wren === 1'b1 && rf_wraddr === 5'd7 && rf_wrdata === 32'h99) saw_new = 1;
      if (rf_wren === 1'b1 && rf_wraddr === 5'd8 && rf_wrdata === 32'h2) saw_8 = 1;
    end
    checks++;
    if (saw_stale || !saw_new || n7 != 1) begin
      failures++;
      $display("FAIL squash_x7: got stale=%0d new=%0d writes=%0d, expected stale=0 new=1 writes=1", saw_stale, saw_new, n7);
    end
    checks++;
    if (!saw_8) begin
      failures++;
      $display("FAIL squash_x8: got written=%0d, expected 1", saw_8);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    repeat (2) step();
    rb_wren   = 1'b1; rb_wraddr = 5'd0; rb_wrdata = $urandom;
    ld_valid  = 1'b1; ld_wraddr = 5'd0; ld_wrdata = $urandom;
    for (int c = 0; c < 4; c++) begin
      step();
      idle_inputs();
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL x0_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 c, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      checks++;
      if (rf_wren !== 1'b0) begin
        failures++;
        $display("FAIL x0_nowrite%0d: got wren=%b, expected 0", c, rf_wren);
      end
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_drained: got ready=%b, expected 1", ld_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rb_wren   = ($urandom_range(0, 99) < ((c < 200) ? 70 : 30));
      rb_wraddr = 5'($urandom_range(0, 7));
      rb_wrdata = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_wraddr = 5'($urandom_range(0, 7));
      ld_wrdata = $urandom;
      step();
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL rand_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 c, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    idle_inputs();
    repeat (8) step();
    for (int c = 0; c < 5; c++) begin
      rb_wren   = (c < 4);
      rb_wraddr = 5'(20 + c);
      rb_wrdata = $urandom;
      ld_valid  = (c < 4);
      ld_wraddr = 5'(c + 1);
      ld_wrdata = $urandom;
      step();
    end
    idle_inputs();
    checks++;
    if (rf_wren !== 1'b1 || rf_wraddr !== 5'd1 || q.size() != 3) begin
      failures++;
      $display("FAIL drain_pre: got wren=%b addr=%0d model_entries=%0d, expected 1/1/3", rf_wren, rf_wraddr, q.size());
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL drain_async: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected 0/0/0/1/0",
               rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= NR + 4; k++) begin
      step();
      checks++;
      if ({rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready} !== {m_wren, m_addr, m_data, m_clr, m_ready()}) begin
        failures++;
        $display("FAIL restart_cyc%0d: got wren=%b addr=%0d data=%h busy=%b rdy=%b, expected wren=%b addr=%0d data=%h busy=%b rdy=%b",
                 k, rf_wren, rf_wraddr, rf_wrdata, init_busy, ld_ready, m_wren, m_addr, m_data, m_clr, m_ready());
      end
      if (k == 1) begin
        checks++;
        if (rf_wren !== 1'b1 || rf_wraddr !== 5'd1) begin
          failures++;
          $display("FAIL restart_first: got wren=%b addr=%0d, expected 1/1", rf_wren, rf_wraddr);
        end
      end
      if (k >= NR) begin
        checks++;
        if (rf_wren !== 1'b0 || ld_ready !== 1'b1) begin
          failures++;
          $display("FAIL restart_empty%0d: got wren=%b rdy=%b, expected 0/1", k, rf_wren, ld_ready);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_ld();
    test_fifo_full();
    test_squash();
    test_x0();
    test_random();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wrport_arb.md
Name: rf_wrport_arb

Overview:
- Owns the single register-file write port and shares it among three sources:
  - the retire stage writeback (highest priority, never stalls);
  - a long-latency writeback requester (`ld_*`), valid/ready with a small FIFO;
  - a post-reset clear sequencer that zeroes the architectural registers.
- Sits between retire/execute writeback and the register file.
- Registers the write command, so every write reaches the register file one cycle after arbitration.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired and never written.
- ADDR_W, 5, register address width; must be at least clog2(NUM_REGS).
- DATA_W, 32, register data width.
- FIFO_DEPTH, 4, `ld` FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- rb_wren, input, 1, retire write request. It has no ready: it is always accepted.
- rb_wraddr, input, ADDR_W, retire destination register.
- rb_wrdata, input, DATA_W, retire result.
- ld_valid, input, 1, long-latency writeback request.
- ld_ready, output, 1, FIFO can accept an `ld` request.
- ld_wraddr, input, ADDR_W, `ld` destination register.
- ld_wrdata, input, DATA_W, `ld` result.
- init_busy, output, 1, clear sequence in progress; upstream holds fetch while this is high.
- rf_wren, output, 1, register-file write enable (registered).
- rf_wraddr, output, ADDR_W, register-file write address (registered).
- rf_wrdata, output, DATA_W, register-file write data (registered).

Behaviour:
- Reset (async assert):
  - outputs: rf_wren=0, rf_wraddr=0, rf_wrdata=0, init_busy=1, ld_ready=0;
  - FIFO emptied (all entry valids cleared);
  - FSM goes to CLEAR with clr_idx=1.
- State CLEAR:
  - each cycle arbitrate {addr=clr_idx, data=0}, then clr_idx++;
  - after the cycle arbitrating clr_idx=NUM_REGS-1, go to RUN;
  - result: NUM_REGS-1 back-to-back rf writes of addresses 1..NUM_REGS-1, appearing on rf_* at cycles 1..NUM_REGS-1 after reset release;
  - init_busy=1 and ld_ready=0 throughout;
  - rb_wren in CLEAR is a protocol violation: ignored, and flagged by the SIMULATION assertion.
- State RUN: init_busy=0. Arbitration in cycle N, with the winner on rf_* at N+1:
  1. rb_wren=1 and rb_wraddr!=0: the retire write wins.
  2. Otherwise, FIFO head valid and head addr!=0: pop the head and write it.
  3. Otherwise: rf_wren=0 next cycle. rf_wraddr and rf_wrdata hold their last values.
- Writes to x0 from either source are dropped with no rf_wren. A dropped `ld` entry is still accepted and popped.
- `ld` FIFO:
  - push when ld_valid & ld_ready;
  - ld_ready = RUN & (count < FIFO_DEPTH), from the registered count; a same-cycle pop does not raise ready;
  - a pushed entry is eligible the cycle after push, so the earliest rf write is push+2;
  - push and pop in the same cycle keep count unchanged;
  - pointers wrap modulo FIFO_DEPTH.
- Ordering squash: the retire write is architecturally younger than every outstanding `ld` entry.
  - In any cycle with rb_wren=1 to address R (R!=0), every FIFO entry with addr=R has its valid cleared, including an entry pushed in that same cycle.
  - An invalid head is popped silently, at most one per cycle. It consumes no write-port slot, and count is decremented.
  - A head squashed in the same cycle it would otherwise win is not written.
- Head selection is never combinational on the same cycle's rb_wren. The only exception is the squash check, which uses rb_wraddr in cycle N.
- The FIFO may be full while retire occupies the port continuously. ld_ready stays 0 and there is no starvation relief; this is by design, since retire bandwidth bounds it.

Optional Feature:
- Macro: RF_WRPORT_ARB_STATS_EN.
- When defined, the block adds three 32-bit saturating output ports, all reset to 0:
  - stat_ld_blocked: cycles with ld_valid & ~ld_ready in RUN;
  - stat_squash: number of FIFO entries invalidated by retire writes, counting each entry;
  - stat_rb_preempt: cycles where retire won while the FIFO head was valid.
- When undefined, these ports and their counters do not exist.
- Functional behaviour is identical in both cases.

Test Plan:
- Reset release with no traffic -> rf_wren high for exactly 31 consecutive cycles, addresses 1..31, data 0. Then init_busy=0 and ld_ready=1 on the following cycle.
- RUN, single `ld` push (addr 5, data 0xDEADBEEF) at cycle N, with no retire traffic -> rf write of 5 / 0xDEADBEEF at N+2.
- Push 4 `ld` entries (addr 1..4), holding ld_valid, while retire writes addr 10..13 over 4 consecutive cycles:
  - ld_ready=0 after the 4th push;
  - the retire writes appear first;
  - then the `ld` writes to addr 1..4, in order, on 4 consecutive cycles.
- FIFO holds addr 7 (data 0x1) and addr 8 (data 0x2); retire writes addr 7 (data 0x99) -> only 7/0x99 and 8/0x2 are written, and the stale 7/0x1 never appears.
- ld_valid to addr 0 and rb_wren to addr 0 in RUN -> no rf_wren; the `ld` request is accepted and popped; count returns to 0.
- Assert reset_n mid-drain with 3 FIFO entries -> rf_wren=0 immediately, FIFO empty, and the clear sequence restarts at address 1 after release.
